// File: rtl/l2tlb_dcresp.sv
// l2tlb_dcresp: L2-TLB responder for the DCTLB miss channel.
// Takes one DCTLB translation request at a time and looks it up in a
// fully-associative table. A hit is acked with the stored ppn and hpaddr.
// A miss issues a page walk and installs the returned fill. If the chosen
// slot holds a valid entry, the victim hpaddr is snooped to the DCTLB, and
// the slot is only rewritten after the matching sack arrives.
// Ports:
//   clk, reset                  clock, async active-high reset
//   dctlbtol2tlb_req_*          DCTLB miss request (valid/retry/vpn/id)
//   l2tlbtodctlb_ack_*          translation ack (valid/retry/ppn/hpaddr/id)
//   l2tlbtodctlb_snoop_*        displacement snoop (valid/retry/hpaddr)
//   dctlbtol2tlb_sack_*         snoop acknowledge (valid/retry/hpaddr)
//   l2tlbtowalk_req_*           page-walk request (valid/retry/vpn)
//   walktol2tlb_fill_*          page-walk fill (valid/retry/ppn)
module l2tlb_dcresp #(
  parameter int ENTRIES  = 8,
  parameter int VPN_W    = 52,
  parameter int PPN_W    = 40,
  parameter int HPADDR_W = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dctlbtol2tlb_req_valid,
  output logic                dctlbtol2tlb_req_retry,
  input  logic [VPN_W-1:0]    dctlbtol2tlb_req_vpn,
  input  logic [1:0]          dctlbtol2tlb_req_id,
  output logic                l2tlbtodctlb_ack_valid,
  input  logic                l2tlbtodctlb_ack_retry,
  output logic [PPN_W-1:0]    l2tlbtodctlb_ack_ppn,
  output logic [HPADDR_W-1:0] l2tlbtodctlb_ack_hpaddr,
  output logic [1:0]          l2tlbtodctlb_ack_id,
  output logic                l2tlbtodctlb_snoop_valid,
  input  logic                l2tlbtodctlb_snoop_retry,
  output logic [HPADDR_W-1:0] l2tlbtodctlb_snoop_hpaddr,
  input  logic                dctlbtol2tlb_sack_valid,
  output logic                dctlbtol2tlb_sack_retry,
  input  logic [HPADDR_W-1:0] dctlbtol2tlb_sack_hpaddr,
  output logic                l2tlbtowalk_req_valid,
  input  logic                l2tlbtowalk_req_retry,
  output logic [VPN_W-1:0]    l2tlbtowalk_req_vpn,
  input  logic                walktol2tlb_fill_valid,
  output logic                walktol2tlb_fill_retry,
  input  logic [PPN_W-1:0]    walktol2tlb_fill_ppn
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [2:0] {
    IDLE, WALK, WAIT_FILL, SNOOP, WAIT_SACK, FILL, ACK
  } state_t;

  state_t state, state_nxt;

  logic [ENTRIES-1:0] ent_valid;
  logic [VPN_W-1:0]   ent_vpn [ENTRIES];
  logic [PPN_W-1:0]   ent_ppn [ENTRIES];

  logic [VPN_W-1:0]    req_vpn_r;
  logic [1:0]          req_id_r;
  logic [PPN_W-1:0]    fill_ppn_r;
  logic [IDX_W-1:0]    victim_r;
  logic [IDX_W-1:0]    ptr_r;
  logic [PPN_W-1:0]    ack_ppn_r;
  logic [HPADDR_W-1:0] ack_hpaddr_r;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             free;
  logic [IDX_W-1:0] free_idx;
  logic             req_xfer, walk_xfer, fill_xfer, snoop_xfer, ack_xfer;
  logic             sack_match;

  function automatic logic [HPADDR_W-1:0] mk_hpaddr(input logic [PPN_W-1:0] ppn,
                                                    input logic [IDX_W-1:0] idx);
    return {ppn[HPADDR_W-IDX_W-1:0], idx};
  endfunction

  // CAM lookup and free-slot search; scanning downward leaves the lowest index.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int unsigned i = ENTRIES; i > 0; i--) begin
      if (ent_valid[i-1] && ent_vpn[i-1] == dctlbtol2tlb_req_vpn) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i-1);
      end
      if (!ent_valid[i-1]) begin
        free     = 1'b1;
        free_idx = IDX_W'(i-1);
      end
    end
  end

  always_comb begin
    dctlbtol2tlb_req_retry    = (state != IDLE);
    walktol2tlb_fill_retry    = (state != WAIT_FILL);
    dctlbtol2tlb_sack_retry   = 1'b0;
    l2tlbtowalk_req_valid     = (state == WALK);
    l2tlbtowalk_req_vpn       = req_vpn_r;
    l2tlbtodctlb_snoop_valid  = (state == SNOOP);
    l2tlbtodctlb_snoop_hpaddr = mk_hpaddr(ent_ppn[victim_r], victim_r);
    l2tlbtodctlb_ack_valid    = (state == ACK);
    l2tlbtodctlb_ack_ppn      = ack_ppn_r;
    l2tlbtodctlb_ack_hpaddr   = ack_hpaddr_r;
    l2tlbtodctlb_ack_id       = req_id_r;

    req_xfer   = dctlbtol2tlb_req_valid && !dctlbtol2tlb_req_retry;
    walk_xfer  = l2tlbtowalk_req_valid && !l2tlbtowalk_req_retry;
    fill_xfer  = walktol2tlb_fill_valid && !walktol2tlb_fill_retry;
    snoop_xfer = l2tlbtodctlb_snoop_valid && !l2tlbtodctlb_snoop_retry;
    ack_xfer   = l2tlbtodctlb_ack_valid && !l2tlbtodctlb_ack_retry;
    sack_match = dctlbtol2tlb_sack_valid &&
                 (dctlbtol2tlb_sack_hpaddr == l2tlbtodctlb_snoop_hpaddr);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (req_xfer)   state_nxt = hit ? ACK : WALK;
      WALK:      if (walk_xfer)  state_nxt = WAIT_FILL;
      WAIT_FILL: if (fill_xfer)  state_nxt = free ? FILL : SNOOP;
      SNOOP:     if (snoop_xfer) state_nxt = WAIT_SACK;
      WAIT_SACK: if (sack_match) state_nxt = FILL;
      FILL:                      state_nxt = ACK;
      ACK:       if (ack_xfer)   state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid    <= '0;
      req_vpn_r    <= '0;
      req_id_r     <= '0;
      fill_ppn_r   <= '0;
      victim_r     <= '0;
      ptr_r        <= '0;
      ack_ppn_r    <= '0;
      ack_hpaddr_r <= '0;
    end else begin
      if (state == IDLE && req_xfer) begin
        req_vpn_r <= dctlbtol2tlb_req_vpn;
        req_id_r  <= dctlbtol2tlb_req_id;
        if (hit) begin
          ack_ppn_r    <= ent_ppn[hit_idx];
          ack_hpaddr_r <= mk_hpaddr(ent_ppn[hit_idx], hit_idx);
        end
      end
      if (state == WAIT_FILL && fill_xfer) begin
        fill_ppn_r <= walktol2tlb_fill_ppn;
        if (free) begin
          victim_r <= free_idx;
        end else begin
          victim_r <= ptr_r;
          ptr_r    <= ptr_r + IDX_W'(1);
        end
      end
      if (state == FILL) begin
        ent_valid[victim_r] <= 1'b1;
        ack_ppn_r           <= fill_ppn_r;
        ack_hpaddr_r        <= mk_hpaddr(fill_ppn_r, victim_r);
      end
    end
  end

  // Entry payload needs no reset: it is only read where the valid bit is set.
  always_ff @(posedge clk) begin
    if (state == FILL) begin
      ent_vpn[victim_r] <= req_vpn_r;
      ent_ppn[victim_r] <= fill_ppn_r;
    end
  end

endmodule
